pipeline_instr_tracker: RTL
===========================

PIPELINE_INSTR_TRACKER -- requirements
Module: pipeline_instr_tracker

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 4: number of consecutive stall cycles that sets stall_timeout.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 if_instruction  in  32  instruction word returned by fetch this cycle.
REQ-007 if_valid  in  1  if_instruction is valid; when 0, a NOP is fetched instead.
REQ-008 stall  in  1  hazard stall request from the stall controller (combinational, same cycle).
REQ-009 flush  in  1  control redirect resolved this cycle; wrong-path instructions are squashed.
REQ-010 pc_write_en  out  1  PC update enable.
REQ-011 ifid_write_en  out  1  IF/ID register load enable.
REQ-012 IFID_instruction_out  out  32  instruction in the ID stage.
REQ-013 IDEX_instruction_out  out  32  instruction in the EX stage.
REQ-014 EXMEM_instruction_out  out  32  instruction in the MEM stage.
REQ-015 MEMWB_instruction_out  out  32  instruction in the WB stage.
REQ-016 pipe_state  out  2  action taken last cycle: RUN=0, STALL=1, FLUSH=2.
REQ-017 stall_timeout  out  1  sticky flag: stall was held for STALL_LIMIT consecutive cycles.
REQ-018 stall_count, flush_count  out  CNT_W each  cycles spent stalling / flushing.

Function
REQ-019 NOP SHALL be 32'h00000013 (addi x0,x0,0).
REQ-020 pc_write_en and ifid_write_en SHALL both be combinational and equal to !(stall && !flush).
REQ-021 Flush priority, on each rising edge with reset=0 and flush=1:
  - IFID <= NOP and IDEX <= NOP.
  - EXMEM <= IDEX and MEMWB <= EXMEM.
  - pipe_state <= FLUSH.
  - flush_count increments.
  - stall is ignored.
REQ-022 Stall-only, when stall=1 and flush=0:
  - IFID holds its value.
  - IDEX <= NOP (bubble).
  - EXMEM <= IDEX and MEMWB <= EXMEM.
  - pipe_state <= STALL.
  - stall_count increments.
REQ-023 Run, when stall=0 and flush=0:
  - IFID <= (if_valid ? if_instruction : NOP).
  - IDEX <= IFID, EXMEM <= IDEX, MEMWB <= EXMEM.
  - pipe_state <= RUN.
REQ-024 pipe_state transitions SHALL be taken from any state and depend only on the current-cycle flush/stall inputs; there are no held or multi-cycle states.
REQ-025 A 3-bit consecutive-stall counter SHALL behave as follows:
  - increments (saturating at 7) on each stall-only cycle;
  - clears on any RUN or FLUSH cycle;
  - when it reaches STALL_LIMIT, stall_timeout <= 1.
REQ-026 stall_timeout SHALL stay set until reset and SHALL NOT clear on a later flush or run.
REQ-027 stall_count and flush_count SHALL wrap modulo 2^CNT_W with no saturation and no overflow flag.
REQ-028 Stage outputs SHALL be driven directly from registers, giving one cycle of latency per stage with no combinational bypass.
REQ-029 When if_valid=0 while stalled, the block SHALL ignore if_valid and IFID SHALL hold.

Reset
REQ-030 While reset=1 at a clock edge, the following SHALL take effect, overriding stall and flush:
  - all four instruction registers = NOP;
  - pipe_state = RUN;
  - stall_timeout = 0;
  - both counters and the consecutive-stall counter = 0.
REQ-031 Reset asserted mid-stall or mid-flush SHALL discard the in-flight instructions; the first post-reset edge with stall=0 SHALL load IFID from fetch.

Structure
REQ-032 The shared pipeline package SHALL hold:
  - the NOP constant;
  - the pipe_state encodings RUN/STALL/FLUSH;
  - the opcode constants used by the stall controller (LOAD 7'b0000011, OP 7'b0110011, OP-IMM 7'b0010011, JALR 7'b1100111).
REQ-033 One sub-module instr_stage_reg SHALL be instantiated four times. It is a 32-bit register with three controls:
  - hold;
  - bubble-insert (load NOP);
  - synchronous reset to NOP.

Verification
REQ-034 Straight-line run: reset, then fetch A,B,C,D with no stall/flush -> A appears in MEMWB_instruction_out on the 4th edge after its fetch; pipe_state=RUN.
REQ-035 Load-use stall: IFID=X, stall=1 for one cycle ->
  - IFID stays X;
  - IDEX=NOP;
  - pc_write_en=0 in that cycle;
  - stall_count=1;
  - on the next edge IDEX=X.
REQ-036 Flush during stall: stall=1 and flush=1 together ->
  - IFID=NOP and IDEX=NOP;
  - pipe_state=FLUSH;
  - stall_count unchanged;
  - flush_count=1;
  - pc_write_en=1.
REQ-037 Timeout: stall held 4 cycles -> stall_timeout=1 after the 4th edge; it stays 1 after a later run and flush and clears only on reset.
REQ-038 Counter wrap with CNT_W=4: 16 stall cycles -> stall_count returns to 0.
REQ-039 Reset mid-stall: reset=1 while stall=1 -> all stage outputs = 32'h00000013, state=RUN, counters=0 after the edge.

Source files
------------

// File: rtl/pipeline_instr_tracker_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_instr_tracker_pkg
// Shared definitions for the 5-stage pipeline instruction tracker and the
// stall controller that feeds it.
//   NOP           : canonical bubble instruction (addi x0,x0,0)
//   pipe_state_e  : action taken by the pipeline in the previous cycle
//   OPC_*         : opcodes the stall controller decodes for hazards
//   opcodeOf()    : helper extracting the opcode field of an instruction
// ---------------------------------------------------------------------------
package pipeline_instr_tracker_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } pipe_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic [6:0] opcodeOf(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/pipeline_instr_tracker_if.sv
// ---------------------------------------------------------------------------
// pipeline_instr_tracker_if
// Bundles the fetch/hazard inputs and the tracker's status outputs.
//   master : driver side (fetch unit, stall controller, testbench)
//            drives if_instruction, if_valid, stall, flush
//   slave  : tracker side, drives pc_write_en, ifid_write_en, the four
//            stage instruction outputs, pipe_state, stall_timeout,
//            stall_count and flush_count
// ---------------------------------------------------------------------------
interface pipeline_instr_tracker_if
    import pipeline_instr_tracker_pkg::*;
#(
    parameter int CNT_W = 16
);

    logic [31:0]      if_instruction;
    logic             if_valid;
    logic             stall;
    logic             flush;

    logic             pc_write_en;
    logic             ifid_write_en;
    logic [31:0]      IFID_instruction_out;
    logic [31:0]      IDEX_instruction_out;
    logic [31:0]      EXMEM_instruction_out;
    logic [31:0]      MEMWB_instruction_out;
    pipe_state_e      pipe_state;
    logic             stall_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output if_instruction, if_valid, stall, flush,
        input  pc_write_en, ifid_write_en,
               IFID_instruction_out, IDEX_instruction_out,
               EXMEM_instruction_out, MEMWB_instruction_out,
               pipe_state, stall_timeout, stall_count, flush_count
    );

    modport slave (
        input  if_instruction, if_valid, stall, flush,
        output pc_write_en, ifid_write_en,
               IFID_instruction_out, IDEX_instruction_out,
               EXMEM_instruction_out, MEMWB_instruction_out,
               pipe_state, stall_timeout, stall_count, flush_count
    );

endinterface

// File: rtl/pipeline_instr_tracker_instr_stage_reg.sv
// ---------------------------------------------------------------------------
// instr_stage_reg
// One 32-bit pipeline instruction register.
//   clk, reset : clock and synchronous active-high reset (loads NOP)
//   hold_i     : keep current contents
//   bubble_i   : load NOP (wins over hold)
//   instr_i    : next instruction when neither hold nor bubble
//   instr_o    : registered instruction
// ---------------------------------------------------------------------------
module instr_stage_reg
    import pipeline_instr_tracker_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hold_i,
    input  logic        bubble_i,
    input  logic [31:0] instr_i,
    output logic [31:0] instr_o
);

    logic [31:0] instr_q;

    // Reset beats bubble, bubble beats hold, so a flush always clears a
    // stage even if the same cycle also asked to hold it.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP;
        end else if (bubble_i) begin
            instr_q <= NOP;
        end else if (!hold_i) begin
            instr_q <= instr_i;
        end
    end

    assign instr_o = instr_q;

endmodule

// File: rtl/pipeline_instr_tracker.sv
// ---------------------------------------------------------------------------
// pipeline_instr_tracker
// Tracks which instruction sits in ID/EX/MEM/WB, applies stall and flush
// control, and keeps stall/flush performance counters.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave modport of pipeline_instr_tracker_if
//                (fetch word/valid, stall, flush in; write enables, stage
//                 instructions, pipe_state, stall_timeout, counters out)
// Parameters: STALL_LIMIT consecutive stalls raise stall_timeout;
//             CNT_W is the counter width (must match the interface).
// ---------------------------------------------------------------------------
module pipeline_instr_tracker
    import pipeline_instr_tracker_pkg::*;
#(
    parameter int STALL_LIMIT = 4,
    parameter int CNT_W       = 16
)(
    input  logic                     clk,
    input  logic                     reset,
    pipeline_instr_tracker_if.slave  bus
);

    logic        stallOnly;
    logic [31:0] fetchInstr;
    logic [31:0] ifidInstr;
    logic [31:0] idexInstr;
    logic [31:0] exmemInstr;
    logic [31:0] memwbInstr;

    pipe_state_e      state_q;
    logic [CNT_W-1:0] stallCount_q;
    logic [CNT_W-1:0] flushCount_q;
    logic [2:0]       consecStall_q;
    logic [2:0]       consecStall_d;
    logic             timeout_q;

    // Flush overrides stall, so a stall only counts when no flush is present.
    assign stallOnly  = bus.stall && !bus.flush;
    assign fetchInstr = bus.if_valid ? bus.if_instruction : NOP;

    assign bus.pc_write_en   = !stallOnly;
    assign bus.ifid_write_en = !stallOnly;

    // IF/ID holds on a stall and is squashed on a flush; IDEX takes a
    // bubble in both cases. Later stages always advance.
    instr_stage_reg uIfid (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (stallOnly),
        .bubble_i (bus.flush),
        .instr_i  (fetchInstr),
        .instr_o  (ifidInstr)
    );

    instr_stage_reg uIdex (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (1'b0),
        .bubble_i (bus.flush || bus.stall),
        .instr_i  (ifidInstr),
        .instr_o  (idexInstr)
    );

    instr_stage_reg uExmem (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (1'b0),
        .bubble_i (1'b0),
        .instr_i  (idexInstr),
        .instr_o  (exmemInstr)
    );

    instr_stage_reg uMemwb (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (1'b0),
        .bubble_i (1'b0),
        .instr_i  (exmemInstr),
        .instr_o  (memwbInstr)
    );

    // Saturating increment of the consecutive-stall run length.
    always_comb begin
        consecStall_d = consecStall_q;
        if (consecStall_q != 3'd7) begin
            consecStall_d = consecStall_q + 3'd1;
        end
    end

    // Pipeline action state, counters and the sticky timeout. The state has
    // no memory of its own: every cycle it reflects the current flush/stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            stallCount_q  <= '0;
            flushCount_q  <= '0;
            consecStall_q <= 3'd0;
            timeout_q     <= 1'b0;
        end else if (bus.flush) begin
            state_q       <= FLUSH;
            flushCount_q  <= flushCount_q + 1'b1;
            consecStall_q <= 3'd0;
        end else if (bus.stall) begin
            state_q       <= STALL;
            stallCount_q  <= stallCount_q + 1'b1;
            consecStall_q <= consecStall_d;
            if ({29'd0, consecStall_d} >= STALL_LIMIT) begin
                timeout_q <= 1'b1;
            end
        end else begin
            state_q       <= RUN;
            consecStall_q <= 3'd0;
        end
    end

    assign bus.IFID_instruction_out  = ifidInstr;
    assign bus.IDEX_instruction_out  = idexInstr;
    assign bus.EXMEM_instruction_out = exmemInstr;
    assign bus.MEMWB_instruction_out = memwbInstr;
    assign bus.pipe_state            = state_q;
    assign bus.stall_timeout         = timeout_q;
    assign bus.stall_count           = stallCount_q;
    assign bus.flush_count           = flushCount_q;

endmodule
